// File: rtl/esn_input_pulse_gen_if.sv
// Sample handshake and reservoir drive bundle for esn_input_pulse_gen.
// The master side feeds samples and the stall. The slave side is the pulse generator.
`timescale 1ns/1ps
interface esn_input_pulse_gen_if #(
  parameter int unsigned N        = 8,
  parameter int unsigned IN_WIDTH = 4
) ();
  logic                       iValid;
  logic signed [IN_WIDTH-1:0] iData;
  logic                       oReady;
  logic                       iHold;
  logic        [N-1:0]        oBitU;
  logic                       oEn;
  logic                       oDone;

  modport master (
    output iValid, iData, iHold,
    input  oReady, oBitU, oEn, oDone
  );

  modport slave (
    input  iValid, iData, iHold,
    output oReady, oBitU, oEn, oDone
  );
endinterface

// File: rtl/esn_input_pulse_gen.sv
// Turns one signed sample into |sample| (saturated) enable pulses that carry a bipolar
// projection pattern into the reservoir cells. A done pulse marks the end of the time step.
`timescale 1ns/1ps
module esn_input_pulse_gen #(
  parameter int unsigned  N          = 8,
  parameter int unsigned  IN_WIDTH   = 4,
  parameter int unsigned  MAX_PULSES = 7,
  parameter logic [N-1:0] PROJ       = N'(8'b10110010)
) (
  input logic                  iClk,
  input logic                  iRst_n,
  esn_input_pulse_gen_if.slave bus
);

  localparam int unsigned          CNT_WIDTH = $clog2(MAX_PULSES + 1);
  localparam logic [IN_WIDTH-1:0]  MAX_CNT   = IN_WIDTH'(MAX_PULSES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, stateNext;
  logic [CNT_WIDTH-1:0] cnt, cntNext;
  logic                 ready, readyNext;
  logic                 en, enNext;
  logic                 done, doneNext;
  logic [N-1:0]         bitU, bitUNext;

  logic [IN_WIDTH-1:0]  dataRaw;
  logic [IN_WIDTH-1:0]  dataAbs;
  logic [IN_WIDTH-1:0]  dataSat;
  logic                 accept;

  // The magnitude is unsigned in IN_WIDTH bits, so the most negative sample maps to 2^(IN_WIDTH-1).
  always_comb begin
    dataRaw = bus.iData;
    dataAbs = dataRaw[IN_WIDTH-1] ? ((~dataRaw) + IN_WIDTH'(1)) : dataRaw;
    dataSat = (dataAbs > MAX_CNT) ? MAX_CNT : dataAbs;
    accept  = ready && bus.iValid;
  end

  // In PULSE, cnt holds the pulses still owed after the one currently on oEn.
  // When cnt is 0, the last pulse is out and DONE follows whatever iHold does.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    readyNext = 1'b0;
    enNext    = 1'b0;
    doneNext  = 1'b0;
    bitUNext  = bitU;

    unique case (state)
      IDLE: begin
        readyNext = 1'b1;
        if (accept) begin
          readyNext = 1'b0;
          bitUNext  = dataRaw[IN_WIDTH-1] ? ~PROJ : PROJ;
          if (dataSat == '0) begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end else begin
            stateNext = PULSE;
            enNext    = 1'b1;
            cntNext   = CNT_WIDTH'(dataSat - IN_WIDTH'(1));
          end
        end
      end

      PULSE: begin
        if (cnt == '0) begin
          stateNext = DONE;
          doneNext  = 1'b1;
        end else if (!bus.iHold) begin
          enNext  = 1'b1;
          cntNext = cnt - CNT_WIDTH'(1);
        end
      end

      DONE: begin
        stateNext = IDLE;
        readyNext = 1'b1;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // The state register and all outputs are registered. Reset clears the burst in flight.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      en    <= 1'b0;
      done  <= 1'b0;
      bitU  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      ready <= readyNext;
      en    <= enNext;
      done  <= doneNext;
      bitU  <= bitUNext;
    end
  end

  assign bus.oReady = ready;
  assign bus.oEn    = en;
  assign bus.oDone  = done;
  assign bus.oBitU  = bitU;

endmodule

// File: tb/tb_esn_input_pulse_gen.sv
// Scoreboard bench for esn_input_pulse_gen.
// The driver schedules the expected pulse and done events, and a monitor compares them against the outputs.
`timescale 1ns/1ps
module tb_esn_input_pulse_gen;

  localparam int unsigned N          = 8;
  localparam int unsigned IN_WIDTH   = 4;
  localparam int unsigned MAX_PULSES = 7;
  localparam logic [N-1:0] PROJ      = 8'b10110010;

  logic iClk = 1'b0;
  logic iRst_n;

  always #5 iClk = ~iClk;

  esn_input_pulse_gen_if #(.N(N), .IN_WIDTH(IN_WIDTH)) bus ();

  esn_input_pulse_gen #(
    .N(N), .IN_WIDTH(IN_WIDTH), .MAX_PULSES(MAX_PULSES), .PROJ(PROJ)
  ) dut (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .bus   (bus)
  );

  typedef struct {
    int           cyc;
    bit           isDone;
    logic [N-1:0] bits;
  } ev_t;

  ev_t sbq[$];
  ev_t mev;
  int  cyc       = 0;
  int  busyUntil = -1;
  int  readyFrom = 1 << 30;
  int  checks    = 0;
  int  errors    = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic pushEv(input int c, input bit d, input logic [N-1:0] b);
    ev_t ev;
    ev.cyc = c; ev.isDone = d; ev.bits = b;
    sbq.push_back(ev);
  endtask

  // Monitor: samples 1 time unit after each rising edge. cyc is the index of the edge just taken.
  always begin
    @(posedge iClk);
    cyc++;
    #1;
    if (!iRst_n) begin
      check("rst_oEn",    32'(bus.oEn),    0);
      check("rst_oDone",  32'(bus.oDone),  0);
      check("rst_oBitU",  32'(bus.oBitU),  0);
      check("rst_oReady", 32'(bus.oReady), 0);
    end else begin
      check("oReady", 32'(bus.oReady), 32'(cyc >= readyFrom && cyc > busyUntil));
      check("en_done_overlap", 32'(bus.oEn & bus.oDone), 0);
      if (bus.oEn || bus.oDone) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 32'({bus.oEn, bus.oDone}), 0);
        end else begin
          mev = sbq.pop_front();
          check("event_cycle", 32'(cyc), 32'(mev.cyc));
          check("event_is_done", 32'(bus.oDone), 32'(mev.isDone));
          if (!mev.isDone) check("oBitU", 32'(bus.oBitU), 32'(mev.bits));
        end
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          mev = sbq.pop_front();
          check("missing_output", 32'({bus.oEn, bus.oDone}), mev.isDone ? 32'd1 : 32'd2);
        end
      end
    end
  end

  // Expected schedule: the first pulse follows acceptance directly, and each later pulse waits out held edges.
  task automatic schedule(input logic signed [IN_WIDTH-1:0] d, input int a,
                          input bit h[64], output int dn);
    int           di, m, rem, e;
    logic [N-1:0] pat;
    di  = int'(d);
    m   = (di < 0) ? -di : di;
    if (m > int'(MAX_PULSES)) m = int'(MAX_PULSES);
    pat = (di < 0) ? ~PROJ : PROJ;
    if (m == 0) begin
      dn = a;
    end else begin
      pushEv(a, 1'b0, pat);
      rem = m - 1;
      e   = a + 1;
      while (rem > 0) begin
        if (!((e - a) < 64 && h[e - a])) begin
          pushEv(e, 1'b0, pat);
          rem--;
        end
        e++;
      end
      dn = e;
    end
    pushEv(dn, 1'b1, '0);
  endtask

  // holdMode: 0 no stall, 1 random stall, 2 stall on the 2nd and 3rd edges after acceptance.
  task automatic doSample(input logic signed [IN_WIDTH-1:0] d, input int holdMode,
                          input bit garbage, input int gap);
    bit h[64];
    int a, dn;
    repeat (gap) begin
      @(negedge iClk);
      bus.iValid = 1'b0;
      bus.iHold  = 1'($urandom);
    end
    @(negedge iClk);
    a = cyc + 1;
    for (int j = 0; j < 64; j++)
      h[j] = (holdMode == 1) ? ($urandom_range(3) == 0) : ((holdMode == 2) && (j == 2 || j == 3));
    schedule(d, a, h, dn);
    busyUntil  = dn;
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iHold  = 1'($urandom);
    for (int k = a; k <= dn; k++) begin
      @(negedge iClk);
      bus.iHold  = ((k + 1 - a) < 64) ? h[k + 1 - a] : 1'b0;
      bus.iValid = garbage ? 1'($urandom) : 1'b0;
      bus.iData  = IN_WIDTH'($urandom);
    end
  endtask

  // Five-pulse burst with reset asserted while the second pulse is on the outputs.
  task automatic doResetMid();
    bit h[64];
    int a, dn;
    @(negedge iClk);
    a = cyc + 1;
    for (int j = 0; j < 64; j++) h[j] = 1'b0;
    schedule(IN_WIDTH'(5), a, h, dn);
    busyUntil  = dn;
    bus.iValid = 1'b1;
    bus.iData  = IN_WIDTH'(5);
    bus.iHold  = 1'b0;
    @(negedge iClk);
    bus.iValid = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b0;
    #1;
    check("midrst_oEn",    32'(bus.oEn),    0);
    check("midrst_oDone",  32'(bus.oDone),  0);
    check("midrst_oBitU",  32'(bus.oBitU),  0);
    check("midrst_oReady", 32'(bus.oReady), 0);
    sbq.delete();
    busyUntil = -1;
    readyFrom = 1 << 30;
    repeat (2) @(negedge iClk);
    iRst_n    = 1'b1;
    readyFrom = cyc + 1;
  endtask

  initial begin
    iRst_n     = 1'b0;
    bus.iValid = 1'b0;
    bus.iData  = '0;
    bus.iHold  = 1'b0;
    repeat (3) @(negedge iClk);
    iRst_n    = 1'b1;
    readyFrom = cyc + 1;

    doSample(IN_WIDTH'(3),  0, 1'b0, 0);
    doSample(-IN_WIDTH'(2), 0, 1'b0, 0);
    doSample(IN_WIDTH'(-8), 0, 1'b1, 1);
    doSample(IN_WIDTH'(0),  0, 1'b0, 2);
    doSample(IN_WIDTH'(4),  2, 1'b0, 0);
    doSample(IN_WIDTH'(5),  0, 1'b1, 0);
    doResetMid();
    doSample(IN_WIDTH'(2),  0, 1'b0, 0);

    repeat (150) doSample(IN_WIDTH'($urandom), 1, 1'($urandom), $urandom_range(2));

    @(negedge iClk);
    bus.iValid = 1'b0;
    repeat (4) @(negedge iClk);
    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
